// File: rtl/mvm_feeder_if.sv
// Byte load stream into the MVM operand feeder: data/valid from the source,
// ready back from the feeder.
interface mvm_feeder_if #(
    parameter int DW = 8
) ();
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/mvm_feeder.sv
// Operand sequencer for the MAC stage: buffers an M x N weight matrix and an
// N-element vector from a byte stream, then replays them as (W[r][c], x[c]) pairs.
module mvm_feeder #(
    parameter int M  = 3,
    parameter int N  = 3,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              reset,
    mvm_feeder_if.slave       s,
    input  logic              reuse_w,
    input  logic              pause,
    output logic [DW-1:0]     mac_a,
    output logic [DW-1:0]     mac_b,
    output logic              mac_valid,
    output logic              mac_last,
    output logic              busy
);

    localparam int WIW = (M * N > 1) ? $clog2(M * N) : 1;
    localparam int XIW = (N > 1) ? $clog2(N) : 1;
    localparam int RIW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        LOAD_W  = 2'd0,
        LOAD_X  = 2'd1,
        COMPUTE = 2'd2
    } state_t;

    state_t            state_r;
    logic [WIW-1:0]    ld_cnt_r;
    logic [RIW-1:0]    r_cnt_r;
    logic [XIW-1:0]    c_cnt_r;
    logic [DW-1:0]     w_buf_r [M*N];
    logic [DW-1:0]     x_buf_r [N];
    logic [DW-1:0]     mac_a_r;
    logic [DW-1:0]     mac_b_r;
    logic              mac_valid_r;
    logic              mac_last_r;
    logic              s_ready_r;
    logic              busy_r;

    logic              xfer_s;
    logic [WIW-1:0]    w_idx_s;
    logic              last_s;

    assign xfer_s  = s.s_valid && s_ready_r;
    assign w_idx_s = WIW'(r_cnt_r) * WIW'(N) + WIW'(c_cnt_r);
    assign last_s  = (r_cnt_r == RIW'(M - 1)) && (c_cnt_r == XIW'(N - 1));

    // Operand buffers; no reset needed since every frame rewrites what it reads.
    always_ff @(posedge clk) begin
        if (xfer_s && (state_r == LOAD_W)) begin
            w_buf_r[ld_cnt_r] <= s.s_data;
        end
        if (xfer_s && (state_r == LOAD_X)) begin
            x_buf_r[ld_cnt_r[XIW-1:0]] <= s.s_data;
        end
    end

    // Load/issue state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= LOAD_W;
            ld_cnt_r    <= WIW'(0);
            r_cnt_r     <= RIW'(0);
            c_cnt_r     <= XIW'(0);
            mac_a_r     <= {DW{1'b0}};
            mac_b_r     <= {DW{1'b0}};
            mac_valid_r <= 1'b0;
            mac_last_r  <= 1'b0;
            s_ready_r   <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                LOAD_W: begin
                    mac_valid_r <= 1'b0;
                    mac_last_r  <= 1'b0;
                    if (xfer_s) begin
                        if (ld_cnt_r == WIW'(M * N - 1)) begin
                            ld_cnt_r <= WIW'(0);
                            state_r  <= LOAD_X;
                        end else begin
                            ld_cnt_r <= ld_cnt_r + WIW'(1);
                        end
                    end
                end
                LOAD_X: begin
                    mac_valid_r <= 1'b0;
                    mac_last_r  <= 1'b0;
                    if (xfer_s) begin
                        if (ld_cnt_r == WIW'(N - 1)) begin
                            ld_cnt_r  <= WIW'(0);
                            state_r   <= COMPUTE;
                            s_ready_r <= 1'b0;
                            busy_r    <= 1'b1;
                        end else begin
                            ld_cnt_r <= ld_cnt_r + WIW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (pause) begin
                        // Operands and indices hold so the paused pair issues next.
                        mac_valid_r <= 1'b0;
                        mac_last_r  <= 1'b0;
                    end else begin
                        mac_a_r     <= w_buf_r[w_idx_s];
                        mac_b_r     <= x_buf_r[c_cnt_r];
                        mac_valid_r <= 1'b1;
                        mac_last_r  <= last_s;
                        if (last_s) begin
                            r_cnt_r   <= RIW'(0);
                            c_cnt_r   <= XIW'(0);
                            state_r   <= reuse_w ? LOAD_X : LOAD_W;
                            s_ready_r <= 1'b1;
                            busy_r    <= 1'b0;
                        end else if (c_cnt_r == XIW'(N - 1)) begin
                            c_cnt_r <= XIW'(0);
                            r_cnt_r <= r_cnt_r + RIW'(1);
                        end else begin
                            c_cnt_r <= c_cnt_r + XIW'(1);
                        end
                    end
                end
                default: begin
                    state_r     <= LOAD_W;
                    ld_cnt_r    <= WIW'(0);
                    r_cnt_r     <= RIW'(0);
                    c_cnt_r     <= XIW'(0);
                    mac_valid_r <= 1'b0;
                    mac_last_r  <= 1'b0;
                    s_ready_r   <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign s.s_ready = s_ready_r;
    assign mac_a     = mac_a_r;
    assign mac_b     = mac_b_r;
    assign mac_valid = mac_valid_r;
    assign mac_last  = mac_last_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mvm_feeder.sv
// Directed table-driven bench for mvm_feeder (M=N=3, DW=8): frame vectors plus a
// hand-written mid-frame reset sequence.
module tb_mvm_feeder;

    logic       clk;
    logic       reset;
    logic       reuse_w;
    logic       pause;
    logic [7:0] mac_a;
    logic [7:0] mac_b;
    logic       mac_valid;
    logic       mac_last;
    logic       busy;

    int checks = 0;
    int errors = 0;

    mvm_feeder_if #(.DW(8)) bus ();

    mvm_feeder #(.M(3), .N(3), .DW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .s         (bus.slave),
        .reuse_w   (reuse_w),
        .pause     (pause),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_valid (mac_valid),
        .mac_last  (mac_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit [0:8][7:0]  w;
        bit [0:2][7:0]  x;
        bit             load_w;
        bit             bubbles;
        bit [15:0]      pmask;
        bit             reuse;
        int             exp_cycles;
        int             exp_first;
        bit [0:2][31:0] exp_dot;
    } vec_t;

    vec_t tbl [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Offers bytes [skip, stop) of the vector's load stream; stop<0 means all.
    task automatic load(input vec_t v, input int skip, input int stop, input string tag);
        logic [7:0] bytes [$];
        int idx, cyc, ph, lim;
        bit xfer;
        bytes = {};
        if (v.load_w) for (int i = 0; i < 9; i++) bytes.push_back(v.w[i]);
        for (int i = 0; i < 3; i++) bytes.push_back(v.x[i]);
        lim = (stop < 0) ? bytes.size() : stop;
        idx = skip; cyc = 0; ph = 0;
        while (idx < lim && cyc < 200) begin
            bus.s_valid = v.bubbles ? (ph % 2 == 0) : 1'b1;
            bus.s_data  = bus.s_valid ? bytes[idx] : 8'h00;
            ph++;
            xfer = bus.s_valid && bus.s_ready;
            tick();
            cyc++;
            if (xfer) idx++;
        end
        bus.s_valid = 1'b0;
        chk({tag, " load_done"}, idx, lim);
    endtask

    // Collects one frame of beats right after the final load transfer.
    task automatic compute(input vec_t v, input string tag);
        int k, j, first, last_k, lows, acc;
        bit done;
        logic [7:0] prev_a, prev_b;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hEE;
        chk({tag, " entry_ready"}, int'(bus.s_ready), 0);
        chk({tag, " entry_busy"}, int'(busy), 1);
        lows = (bus.s_ready == 1'b0) ? 1 : 0;
        k = 0; j = 0; first = -1; last_k = -1; acc = 0; done = 1'b0;
        prev_a = 8'h00; prev_b = 8'h00;
        while (!done && k < 40) begin
            pause   = (k + 1 < 16) ? v.pmask[k+1] : 1'b0;
            reuse_w = v.reuse;
            tick();
            k++;
            if (mac_valid) begin
                if (first < 0) first = k;
                if (j < 9) begin
                    chk($sformatf("%s a[%0d]", tag, j), int'(mac_a), int'(v.w[j]));
                    chk($sformatf("%s b[%0d]", tag, j), int'(mac_b), int'(v.x[j%3]));
                    chk($sformatf("%s last[%0d]", tag, j), int'(mac_last), (j == 8) ? 1 : 0);
                    acc += int'($signed(mac_a)) * int'($signed(mac_b));
                    if (j % 3 == 2) begin
                        chk($sformatf("%s dot[%0d]", tag, j / 3), acc, int'(v.exp_dot[j/3]));
                        acc = 0;
                    end
                end
                prev_a = mac_a;
                prev_b = mac_b;
                j++;
                if (mac_last) begin
                    done = 1'b1;
                    last_k = k;
                end
            end else if (j > 0) begin
                chk($sformatf("%s hold_a k%0d", tag, k), int'(mac_a), int'(prev_a));
                chk($sformatf("%s hold_b k%0d", tag, k), int'(mac_b), int'(prev_b));
            end
            if (!done) begin
                chk($sformatf("%s busy k%0d", tag, k), int'(busy), 1);
                if (bus.s_ready == 1'b0) lows++;
            end
        end
        bus.s_valid = 1'b0;
        pause   = 1'b0;
        reuse_w = 1'b0;
        chk({tag, " frame_done"}, int'(done), 1);
        chk({tag, " beats"}, j, 9);
        chk({tag, " cycles"}, last_k, v.exp_cycles);
        chk({tag, " first_beat"}, first, v.exp_first);
        chk({tag, " ready_low_cycles"}, lows, v.exp_cycles);
        chk({tag, " busy_at_last"}, int'(busy), 0);
        chk({tag, " ready_at_last"}, int'(bus.s_ready), 1);
        tick();
        chk({tag, " valid_after"}, int'(mac_valid), 0);
    endtask

    initial begin
        int nbeats, busy_cycles;

        // Base: W=1..9, x=1,2,3 -> 14,32,50.
        tbl[0].w = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        tbl[0].x = {8'd1, 8'd2, 8'd3};
        tbl[0].load_w = 1'b1; tbl[0].bubbles = 1'b0; tbl[0].pmask = 16'h0000;
        tbl[0].reuse = 1'b0; tbl[0].exp_cycles = 9; tbl[0].exp_first = 1;
        tbl[0].exp_dot = {32'd14, 32'd32, 32'd50};
        // Load bubbles.
        tbl[1] = tbl[0]; tbl[1].bubbles = 1'b1;
        // Pause in COMPUTE cycles 3 and 4.
        tbl[2] = tbl[0]; tbl[2].pmask = 16'h0018; tbl[2].exp_cycles = 11;
        // Request weight reuse at the end of this frame.
        tbl[3] = tbl[0]; tbl[3].reuse = 1'b1;
        // Vector-only load x=-1: -6,-15,-24.
        tbl[4] = tbl[0]; tbl[4].load_w = 1'b0;
        tbl[4].x = {8'hFF, 8'hFF, 8'hFF};
        tbl[4].exp_dot = {-32'sd6, -32'sd15, -32'sd24};
        // Signed extremes: 3 * (-128 * 127) = -48768.
        tbl[5] = tbl[0];
        tbl[5].w = {9{8'h80}};
        tbl[5].x = {3{8'h7F}};
        tbl[5].exp_dot = {-32'sd48768, -32'sd48768, -32'sd48768};
        // Mixed signs with bubbles and a pause on the first COMPUTE cycle.
        tbl[6] = tbl[0];
        tbl[6].w = {8'hFF, 8'h02, 8'hFD, 8'h04, 8'hFB, 8'h06, 8'hF9, 8'h08, 8'hF7};
        tbl[6].x = {8'h03, 8'hFE, 8'h01};
        tbl[6].bubbles = 1'b1; tbl[6].pmask = 16'h0002;
        tbl[6].exp_cycles = 10; tbl[6].exp_first = 2;
        tbl[6].exp_dot = {-32'sd10, 32'sd28, -32'sd46};

        reset = 1'b1; reuse_w = 1'b0; pause = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = 8'h00;
        tick();
        tick();
        chk("rst s_ready", int'(bus.s_ready), 1);
        chk("rst busy", int'(busy), 0);
        chk("rst mac_valid", int'(mac_valid), 0);
        chk("rst mac_last", int'(mac_last), 0);
        chk("rst mac_a", int'(mac_a), 0);
        chk("rst mac_b", int'(mac_b), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            load(tbl[i], 0, -1, $sformatf("v%0d", i));
            compute(tbl[i], $sformatf("v%0d", i));
        end

        // Reset after 4 beats aborts the frame.
        load(tbl[0], 0, -1, "rs");
        bus.s_valid = 1'b1; bus.s_data = 8'hEE;
        nbeats = 0;
        for (int k = 0; k < 20 && nbeats < 4; k++) begin
            tick();
            if (mac_valid) nbeats++;
        end
        chk("rs beats_before_reset", nbeats, 4);
        reset = 1'b1;
        bus.s_valid = 1'b0;
        tick();
        reset = 1'b0;
        chk("rs mac_valid", int'(mac_valid), 0);
        chk("rs busy", int'(busy), 0);
        chk("rs s_ready", int'(bus.s_ready), 1);
        chk("rs mac_last", int'(mac_last), 0);

        // Three bytes alone must not start COMPUTE.
        load(tbl[0], 0, 3, "rs3");
        busy_cycles = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (busy || mac_valid || !bus.s_ready) busy_cycles++;
        end
        chk("rs3 no_compute", busy_cycles, 0);

        // Completing the full 12-byte load resumes normal operation.
        load(tbl[0], 3, -1, "rs12");
        compute(tbl[0], "rs12");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
